// File: rtl/spi_target.sv
// SPI target endpoint. SCK, CS_n and MOSI are oversampled in the clk domain.
// Frames of 1..DATA_W bits are shifted in and out in any CPOL/CPHA mode.
// Received words are offered on a valid/ready port. Transmit words come in
// through a single-entry holding buffer.
module spi_target #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [3:0]        cfg_frame_size,
  input  logic              spi_sck_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  input  logic              err_clr_i
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers. Edges are taken one flop past the last synchronizer stage.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;

  // Synchronizer chains plus the edge-detect history flops, reset to idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= {SYNC_STAGES{cfg_cpol}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= cfg_cpol;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CW-1:0]     size_q, size_d, bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] txb_q, txb_d, rx_data_q, rx_data_d;
  logic              txb_vld_q, txb_vld_d, rx_vld_q, rx_vld_d;
  logic              ovr_q, ovr_d, udr_q, udr_d;

  logic              cs_fall, cs_rise, sck_edge, lead_e, trail_e, sample_e, drive_e;
  logic [CW-1:0]     size_in, rx_idx, load_size;
  logic              do_load, load_lsb, rx_done, ovr_set, udr_set, rx_busy;
  logic [DATA_W-1:0] load_word, rx_word;

  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign sck_edge = sck_s ^ sck_prev_q;
  // Leading edge moves away from the idle level, trailing edge returns to it
  assign lead_e   = sck_edge & (sck_s != cpol_q);
  assign trail_e  = sck_edge & (sck_s == cpol_q);
  assign sample_e = cpha_q ? trail_e : lead_e;
  assign drive_e  = cpha_q ? lead_e : trail_e;

  // Out-of-range sizes (0 or wider than the datapath) mean a full-width frame
  assign size_in = (cfg_frame_size == '0 || int'(cfg_frame_size) > DATA_W)
                   ? CW'(DATA_W) : CW'(cfg_frame_size);

  // Bit position the next sampled MOSI bit lands in; word stays right-aligned
  assign rx_idx  = lsb_q ? bit_cnt_q : (size_q - CW'(1) - bit_cnt_q);

  // A held rx word that is being accepted this cycle counts as free
  assign rx_busy = rx_vld_q & ~rx_ready_i;

  // Next-state logic: frame FSM, shifters, tx buffer, rx handshake, sticky flags
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    size_d     = size_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    txb_d      = txb_q;
    txb_vld_d  = txb_vld_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = rx_busy;
    do_load    = 1'b0;
    load_lsb   = lsb_q;
    load_size  = size_q;
    load_word  = '1;
    rx_done    = 1'b0;
    rx_word    = '0;
    ovr_set    = 1'b0;
    udr_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d    = S_ACTIVE;
          cpol_d     = cfg_cpol;
          cpha_d     = cfg_cpha;
          lsb_d      = cfg_lsb_first;
          size_d     = size_in;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          // CPHA=0 must have bit 0 on the wire before the first sample edge
          if (!cfg_cpha) begin
            do_load   = 1'b1;
            load_lsb  = cfg_lsb_first;
            load_size = size_in;
          end
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          // Abandon any partial frame; SCK activity is ignored from here on
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '1;
        end else begin
          if (sample_e) begin
            for (int i = 0; i < DATA_W; i++)
              if (CW'(i) == rx_idx) rx_shift_d[i] = mosi_s;
            if (bit_cnt_q + CW'(1) == size_q) begin
              rx_done    = 1'b1;
              rx_word    = rx_shift_d;
              rx_shift_d = '0;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (drive_e) begin
            // A drive edge at bit 0 starts a new frame, otherwise advance a bit
            if (bit_cnt_q == '0) do_load = 1'b1;
            else if (lsb_q)      tx_shift_d = {1'b1, tx_shift_q[DATA_W-1:1]};
            else                 tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b1};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame load consumes the holding buffer; an empty buffer sends all ones
    if (do_load) begin
      if (txb_vld_q) load_word = txb_q;
      else           udr_set   = 1'b1;
      txb_vld_d  = 1'b0;
      tx_shift_d = load_lsb ? load_word : (load_word << (CW'(DATA_W) - load_size));
    end

    // A write lands after a same-cycle load, so the new word is kept
    if (tx_valid_i && !txb_vld_q) begin
      txb_d     = tx_data_i;
      txb_vld_d = 1'b1;
    end

    if (rx_done) begin
      if (!rx_busy) begin
        rx_data_d = rx_word;
        rx_vld_d  = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    // Set events win over a same-cycle clear
    ovr_d = (ovr_q & ~err_clr_i) | ovr_set;
    udr_d = (udr_q & ~err_clr_i) | udr_set;
  end

  // Frame state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      size_q     <= CW'(DATA_W);
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '1;
      txb_q      <= '0;
      txb_vld_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      size_q     <= size_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      txb_q      <= txb_d;
      txb_vld_q  <= txb_vld_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
    end
  end

  assign spi_miso_o    = lsb_q ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
  assign spi_miso_oe_o = (state_q == S_ACTIVE);
  assign tx_ready_o    = ~txb_vld_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_vld_q;
  assign busy_o        = ~cs_s;
  assign rx_overrun_o  = ovr_q;
  assign tx_underrun_o = udr_q;

endmodule
